// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: datapath width, register-index width and the
// write-back source codes. The decoder uses the same constants.
package cpu_defs_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;

    // Write-back source codes carried by wd_sel
    localparam logic [1:0] RETURN_PC  = 2'b00;
    localparam logic [1:0] ALU_RESULT = 2'b01;
    localparam logic [1:0] MEM_DATA   = 2'b10;

    // Destination tracking for an instruction in flight
    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic             we;
        logic             is_load;
    } stage_t;

    // A stage hits a source operand when it writes that register, the
    // register is not x0, and the ID instruction really reads it.
    function automatic logic reg_hit(
        input logic [REG_W-1:0] stage_rd,
        input logic             stage_we,
        input logic [REG_W-1:0] rs,
        input logic             rs_used,
        input logic             id_valid
    );
        return stage_we && (stage_rd == rs) && (rs != '0) && rs_used && id_valid;
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// Per-operand forwarding: hit detection in EX, MEM and WB with EX > MEM > WB
// priority. A hit on a load still in EX cannot be forwarded; it is reported
// so the top can stall, and the select stays low.
module fwd_mux
    import cpu_defs_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic             i_id_valid,
    input  logic [REG_W-1:0] i_rs,
    input  logic             i_rs_used,
    input  logic [REG_W-1:0] i_ex_rd,
    input  logic             i_ex_we,
    input  logic             i_ex_is_load,
    input  logic [REG_W-1:0] i_mem_rd,
    input  logic             i_mem_we,
    input  logic             i_mem_is_load,
    input  logic [REG_W-1:0] i_wb_rd,
    input  logic             i_wb_we,
    input  logic [W-1:0]     i_ex_wd,
    input  logic [W-1:0]     i_mem_wd,
    input  logic [W-1:0]     i_mem_rdata,
    input  logic [W-1:0]     i_wb_wd,
    output logic             o_sel,
    output logic [W-1:0]     o_data,
    output logic             o_ex_load_hit
);

    logic w_ex_hit;
    logic w_mem_hit;
    logic w_wb_hit;

    assign w_ex_hit  = reg_hit(i_ex_rd,  i_ex_we,  i_rs, i_rs_used, i_id_valid);
    assign w_mem_hit = reg_hit(i_mem_rd, i_mem_we, i_rs, i_rs_used, i_id_valid);
    assign w_wb_hit  = reg_hit(i_wb_rd,  i_wb_we,  i_rs, i_rs_used, i_id_valid);

    // Priority select; the youngest writer wins
    always_comb begin
        o_sel         = 1'b0;
        o_data        = '0;
        o_ex_load_hit = 1'b0;
        if (w_ex_hit) begin
            if (i_ex_is_load) begin
                o_ex_load_hit = 1'b1;
            end else begin
                o_sel  = 1'b1;
                o_data = i_ex_wd;
            end
        end else if (w_mem_hit) begin
            o_sel  = 1'b1;
            o_data = i_mem_is_load ? i_mem_rdata : i_mem_wd;
        end else if (w_wb_hit) begin
            o_sel  = 1'b1;
            o_data = i_wb_wd;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard and forwarding unit beside the ID stage: tracks destinations in
// EX/MEM/WB, drives operand forwards into decode, raises a one-cycle
// load-use stall and counts stall and flush cycles.
module hazard_forward_unit #(
    parameter int XLEN = cpu_defs_pkg::XLEN
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            id_valid_i,
    input  logic [4:0]      id_rs1_i,
    input  logic [4:0]      id_rs2_i,
    input  logic            id_rs1_used_i,
    input  logic            id_rs2_used_i,
    input  logic [4:0]      id_rd_i,
    input  logic            id_we_i,
    input  logic [1:0]      id_wd_sel_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] ex_wd_i,
    input  logic [XLEN-1:0] mem_wd_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    input  logic [XLEN-1:0] wb_wd_i,
    output logic            fwd_sel_1_o,
    output logic            fwd_sel_2_o,
    output logic [XLEN-1:0] fwd_data_1_o,
    output logic [XLEN-1:0] fwd_data_2_o,
    output logic            stall_o,
    output logic [31:0]     stall_cnt_o,
    output logic [31:0]     flush_cnt_o
);
    import cpu_defs_pkg::*;

    stage_t           r_ex;
    stage_t           r_mem;
    logic [REG_W-1:0] r_wb_rd;
    logic             r_wb_we;
    logic [31:0]      r_stall_cnt;
    logic [31:0]      r_flush_cnt;

    logic             w_ex_load_hit_1;
    logic             w_ex_load_hit_2;
    logic             w_stall;
    logic             w_bubble;
    stage_t           w_id_stage;

    fwd_mux #(.W(XLEN)) u_fwd_rs1 (
        .i_id_valid    (id_valid_i),
        .i_rs          (id_rs1_i),
        .i_rs_used     (id_rs1_used_i),
        .i_ex_rd       (r_ex.rd),
        .i_ex_we       (r_ex.we),
        .i_ex_is_load  (r_ex.is_load),
        .i_mem_rd      (r_mem.rd),
        .i_mem_we      (r_mem.we),
        .i_mem_is_load (r_mem.is_load),
        .i_wb_rd       (r_wb_rd),
        .i_wb_we       (r_wb_we),
        .i_ex_wd       (ex_wd_i),
        .i_mem_wd      (mem_wd_i),
        .i_mem_rdata   (mem_rdata_i),
        .i_wb_wd       (wb_wd_i),
        .o_sel         (fwd_sel_1_o),
        .o_data        (fwd_data_1_o),
        .o_ex_load_hit (w_ex_load_hit_1)
    );

    fwd_mux #(.W(XLEN)) u_fwd_rs2 (
        .i_id_valid    (id_valid_i),
        .i_rs          (id_rs2_i),
        .i_rs_used     (id_rs2_used_i),
        .i_ex_rd       (r_ex.rd),
        .i_ex_we       (r_ex.we),
        .i_ex_is_load  (r_ex.is_load),
        .i_mem_rd      (r_mem.rd),
        .i_mem_we      (r_mem.we),
        .i_mem_is_load (r_mem.is_load),
        .i_wb_rd       (r_wb_rd),
        .i_wb_we       (r_wb_we),
        .i_ex_wd       (ex_wd_i),
        .i_mem_wd      (mem_wd_i),
        .i_mem_rdata   (mem_rdata_i),
        .i_wb_wd       (wb_wd_i),
        .o_sel         (fwd_sel_2_o),
        .o_data        (fwd_data_2_o),
        .o_ex_load_hit (w_ex_load_hit_2)
    );

    // A flush discards the ID instruction, so it also cancels its stall
    assign w_stall  = (w_ex_load_hit_1 | w_ex_load_hit_2) & ~flush_i;
    assign w_bubble = w_stall | flush_i;
    assign stall_o  = w_stall;

    assign w_id_stage.rd      = id_rd_i;
    assign w_id_stage.we      = id_we_i & id_valid_i;
    assign w_id_stage.is_load = (id_wd_sel_i == MEM_DATA);

    // Destination tracking; MEM and WB always advance, EX takes a bubble on stall/flush
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_ex    <= '0;
            r_mem   <= '0;
            r_wb_rd <= '0;
            r_wb_we <= 1'b0;
        end else begin
            r_wb_rd <= r_mem.rd;
            r_wb_we <= r_mem.we;
            r_mem   <= r_ex;
            r_ex    <= w_bubble ? '0 : w_id_stage;
        end
    end

    // Free-running event counters, wrapping modulo 2^32
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall) r_stall_cnt <= r_stall_cnt + 32'd1;
            if (flush_i) r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Randomized and directed bench for hazard_forward_unit against a
// behavioural model holding the last three issued instructions.
module tb_hazard_forward_unit;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        id_valid_i;
    logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
    logic        id_rs1_used_i, id_rs2_used_i, id_we_i;
    logic [1:0]  id_wd_sel_i;
    logic        flush_i;
    logic [31:0] ex_wd_i, mem_wd_i, mem_rdata_i, wb_wd_i;
    logic        fwd_sel_1_o, fwd_sel_2_o, stall_o;
    logic [31:0] fwd_data_1_o, fwd_data_2_o, stall_cnt_o, flush_cnt_o;

    int checks = 0;
    int errors = 0;

    // Model: age 0 = EX, 1 = MEM, 2 = WB
    logic [4:0]  m_rd [3];
    logic        m_we [3];
    logic        m_ld [3];
    logic [31:0] m_stall_cnt, m_flush_cnt;
    logic        exp_stall;

    always #5 clk_i = ~clk_i;

    hazard_forward_unit #(.XLEN(32)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
        .id_rd_i(id_rd_i), .id_we_i(id_we_i), .id_wd_sel_i(id_wd_sel_i),
        .flush_i(flush_i), .ex_wd_i(ex_wd_i), .mem_wd_i(mem_wd_i),
        .mem_rdata_i(mem_rdata_i), .wb_wd_i(wb_wd_i),
        .fwd_sel_1_o(fwd_sel_1_o), .fwd_sel_2_o(fwd_sel_2_o),
        .fwd_data_1_o(fwd_data_1_o), .fwd_data_2_o(fwd_data_2_o),
        .stall_o(stall_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < 3; s++) begin
            m_rd[s] = '0; m_we[s] = 1'b0; m_ld[s] = 1'b0;
        end
        m_stall_cnt = '0;
        m_flush_cnt = '0;
    endtask

    // Search youngest-first for a writer of rs
    task automatic model_operand(input logic [4:0] rs, input logic used,
                                 output logic sel, output logic [31:0] data,
                                 output logic ldhit);
        logic found;
        sel = 1'b0; data = '0; ldhit = 1'b0; found = 1'b0;
        if (id_valid_i && used && rs != 5'd0) begin
            for (int s = 0; s < 3; s++) begin
                if (!found && m_we[s] && m_rd[s] == rs) begin
                    found = 1'b1;
                    if (s == 0 && m_ld[0]) ldhit = 1'b1;
                    else begin
                        sel = 1'b1;
                        if (s == 0)      data = ex_wd_i;
                        else if (s == 1) data = m_ld[1] ? mem_rdata_i : mem_wd_i;
                        else             data = wb_wd_i;
                    end
                end
            end
        end
    endtask

    task automatic compare_model();
        logic s1, s2, l1, l2;
        logic [31:0] d1, d2;
        model_operand(id_rs1_i, id_rs1_used_i, s1, d1, l1);
        model_operand(id_rs2_i, id_rs2_used_i, s2, d2, l2);
        exp_stall = (l1 | l2) & ~flush_i;
        chk("sel1", {31'd0, fwd_sel_1_o}, {31'd0, s1});
        chk("sel2", {31'd0, fwd_sel_2_o}, {31'd0, s2});
        chk("data1", fwd_data_1_o, d1);
        chk("data2", fwd_data_2_o, d2);
        chk("stall", {31'd0, stall_o}, {31'd0, exp_stall});
        chk("stall_cnt", stall_cnt_o, m_stall_cnt);
        chk("flush_cnt", flush_cnt_o, m_flush_cnt);
    endtask

    task automatic settle();
        #1;
        if (!reset_i) model_clear();
    endtask

    task automatic advance();
        if (reset_i) begin
            if (exp_stall) m_stall_cnt++;
            if (flush_i)   m_flush_cnt++;
            for (int s = 2; s > 0; s--) begin
                m_rd[s] = m_rd[s-1]; m_we[s] = m_we[s-1]; m_ld[s] = m_ld[s-1];
            end
            if (exp_stall || flush_i) begin
                m_rd[0] = '0; m_we[0] = 1'b0; m_ld[0] = 1'b0;
            end else begin
                m_rd[0] = id_rd_i;
                m_we[0] = id_we_i & id_valid_i;
                m_ld[0] = (id_wd_sel_i == 2'b10);
            end
        end
        @(negedge clk_i);
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2,
                          input logic [4:0] rd, input logic we, input logic [1:0] sel);
        id_valid_i = v; id_rs1_i = rs1; id_rs1_used_i = u1;
        id_rs2_i = rs2; id_rs2_used_i = u2;
        id_rd_i = rd; id_we_i = we; id_wd_sel_i = sel;
    endtask

    task automatic step();
        settle();
        compare_model();
        advance();
    endtask

    initial begin
        reset_i = 1'b0; flush_i = 1'b0;
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 2'b01);
        ex_wd_i = 32'h1; mem_wd_i = 32'h2; mem_rdata_i = 32'h3; wb_wd_i = 32'h4;
        model_clear();
        exp_stall = 1'b0;
        #1;
        chk("rst_sel1", {31'd0, fwd_sel_1_o}, 32'd0);
        chk("rst_data2", fwd_data_2_o, 32'd0);
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_cnt", stall_cnt_o | flush_cnt_o, 32'd0);
        @(negedge clk_i); @(negedge clk_i);
        reset_i = 1'b1;

        // addi x5 then read x5 from EX
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 2'b01); step();
        set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'b01);
        ex_wd_i = 32'h11;
        settle(); compare_model();
        chk("t1_sel1", {31'd0, fwd_sel_1_o}, 32'd1);
        chk("t1_data1", fwd_data_1_o, 32'h11);
        chk("t1_stall", {31'd0, stall_o}, 32'd0);
        advance();

        // lw x6 then read x6 on rs2: one stall, then forward load data from MEM
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 2'b10); step();
        set_id(1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 5'd0, 1'b0, 2'b01);
        settle(); compare_model();
        chk("t2_stall", {31'd0, stall_o}, 32'd1);
        chk("t2_sel2", {31'd0, fwd_sel_2_o}, 32'd0);
        chk("t2_cnt0", stall_cnt_o, 32'd0);
        advance();
        mem_rdata_i = 32'hDEAD;
        settle(); compare_model();
        chk("t2_sel2b", {31'd0, fwd_sel_2_o}, 32'd1);
        chk("t2_data2", fwd_data_2_o, 32'hDEAD);
        chk("t2_stallb", {31'd0, stall_o}, 32'd0);
        chk("t2_cnt1", stall_cnt_o, 32'd1);
        advance();

        // x7 in EX and MEM: EX wins
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 2'b01); step();
        step();
        set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'b01);
        ex_wd_i = 32'hA; mem_wd_i = 32'hB;
        settle(); compare_model();
        chk("t3_data1", fwd_data_1_o, 32'hA);
        advance();

        // write to x0 reaching WB is never forwarded
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 2'b01); step();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b01); step();
        step();
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'b01);
        wb_wd_i = 32'h55;
        settle(); compare_model();
        chk("t4_sel1", {31'd0, fwd_sel_1_o}, 32'd0);
        chk("t4_data1", fwd_data_1_o, 32'd0);
        advance();

        // EX-load hit during flush: no stall, bubble goes into EX
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 2'b10); step();
        set_id(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 2'b01);
        flush_i = 1'b1;
        settle(); compare_model();
        chk("t5_stall", {31'd0, stall_o}, 32'd0);
        chk("t5_fcnt0", flush_cnt_o, 32'd0);
        advance();
        flush_i = 1'b0;
        ex_wd_i = 32'h1234; mem_rdata_i = 32'h777;
        settle(); compare_model();
        chk("t5_fcnt1", flush_cnt_o, 32'd1);
        chk("t5_data1", fwd_data_1_o, 32'h777);
        chk("t5_stallb", {31'd0, stall_o}, 32'd0);
        advance();

        // reset mid-flight with three writers
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 2'b01); step();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 2'b01); step();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 2'b01); step();
        set_id(1'b1, 5'd10, 1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 2'b01);
        settle(); compare_model();
        chk("t6_pre_sel1", {31'd0, fwd_sel_1_o}, 32'd1);
        reset_i = 1'b0;
        settle();
        chk("t6_sel1", {31'd0, fwd_sel_1_o}, 32'd0);
        chk("t6_sel2", {31'd0, fwd_sel_2_o}, 32'd0);
        chk("t6_data1", fwd_data_1_o, 32'd0);
        chk("t6_cnt", stall_cnt_o | flush_cnt_o, 32'd0);
        exp_stall = 1'b0;
        @(negedge clk_i);
        reset_i = 1'b1;
        settle(); compare_model();
        chk("t6_post_sel1", {31'd0, fwd_sel_1_o}, 32'd0);
        chk("t6_post_sel2", {31'd0, fwd_sel_2_o}, 32'd0);
        advance();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset_i = ($urandom_range(0, 299) != 0);
            set_id($urandom_range(0, 9) != 0,
                   5'($urandom_range(0, 7)), 1'($urandom),
                   5'($urandom_range(0, 7)), 1'($urandom),
                   5'($urandom_range(0, 7)), 1'($urandom),
                   2'($urandom_range(0, 3)));
            flush_i     = ($urandom_range(0, 9) == 0);
            ex_wd_i     = $urandom;
            mem_wd_i    = $urandom;
            mem_rdata_i = $urandom;
            wb_wd_i     = $urandom;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
